vec_proc_param: RTL and testbench
=================================

// Module: vec_proc_param
// PURPOSE
//  Parametrised successor of the 4x512-bit vector PROCESSOR: LANES x LANE_W vector regs R0..R3,
//  internal word memory, lane-serial LOAD/STORE/ADD/SUB/MUL with valid/ready instruction handshake,
//  done/error status. Sits between instruction sequencer and host; host preloads memory via write port.
// PARAMETERS
//  LANES      16   lanes per vector register
//  LANE_W     32   bits per lane / memory word
//  ADDR_W     9    memory address width; MEM_DEPTH = 2**ADDR_W words
// PORTS
//  clk         in   1               clock, rising edge
//  reset       in   1               asynchronous, active-low reset
//  instr       in   16              [15:14] op, [13:11] func, [10:9] reg, [8:0] addr (ADDR_W<=9 used)
//  instr_valid in   1               instruction offered
//  instr_ready out  1               high only in IDLE
//  mem_we      in   1               host memory write strobe (honoured only in IDLE)
//  mem_waddr   in   ADDR_W          host write address
//  mem_wdata   in   LANE_W          host write data
//  dbg_sel     in   2               register selected for dbg_data
//  dbg_data    out  LANES*LANE_W    combinational view of R[dbg_sel], lane 0 in LSBs
//  busy        out  1               high from accept until done
//  done        out  1               one-cycle pulse at instruction completion
//  error       out  1               sticky; set on illegal func, cleared by next accepted instr
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE, R0..R3=0, lane ctr=0, busy=0, done=0, error=0,
//   instr_ready=1. Memory contents NOT reset. Reset mid-op aborts; partial results discarded.
//  Accept: instr_valid&&instr_ready at edge -> latch op/func/reg/addr, go to op state, busy=1.
//  States: IDLE, LOAD, STORE, EXEC, DONE.
//   LOAD  (op 00): lane i <= mem[(addr+i) mod MEM_DEPTH], i=0..LANES-1, one lane/cycle -> R[reg].
//   STORE (op 01): mem[(addr+i) mod MEM_DEPTH] <= R[reg] lane i, one lane/cycle.
//   EXEC  (op 10, ADD): func 000: R2[i] <= R0[i]+R1[i]; func 001: R2[i] <= R0[i]-R1[i];
//         modulo 2**LANE_W, no saturation; R3 untouched.
//   EXEC  (op 11, MUL): 2*LANE_W product P=R0[i]*R1[i]; func 000 signed, 001 unsigned;
//         R2[i] <= P[LANE_W-1:0], R3[i] <= P[2*LANE_W-1:LANE_W].
//   reg/addr fields ignored by ADD/MUL. Other func codes: no register/memory change,
//   error=1, straight to DONE.
//   DONE: done=1 for one cycle, busy=0, return to IDLE; instr_ready=1 again next cycle.
//  Latency: accept edge -> LANES lane cycles -> DONE cycle; done asserted LANES+1 cycles after
//   accept edge (illegal func: 1 cycle). Throughput: one instr per LANES+2 cycles.
//  Wrap-around: address addr+i wraps mod MEM_DEPTH (addr=510, LANES=16 -> 510,511,0..13).
//  Simultaneous mem_we and instr accept in IDLE: write commits at that edge; a LOAD reading
//   same address sees new data. mem_we while busy: silently ignored.
//  Lane i results written only at lane i's cycle; op sources read same cycle, so reg==source
//   LOAD/STORE hazards impossible (single instruction in flight).
//  dbg_data reflects registered state (updates per lane during an op).
// STRUCTURE
//  Package vec_proc_pkg: op codes (OP_LOAD=2'b00, OP_STORE=2'b01, OP_ADD=2'b10, OP_MUL=2'b11),
//   func codes, state encoding, instr field bit positions.
//  One sub-module: vec_lane_alu (LANE_W-wide add/sub/signed-unsigned mul, combinational,
//   outputs lo/hi). Top holds FSM, lane counter, register file, memory array.
// TESTING (LANES=16, LANE_W=32, ADDR_W=9)
//  1 Host writes mem[k]=k for k=0..31; LOAD R0 addr 0; LOAD R1 addr 16 -> dbg R0 lanes 0..15,
//    R1 lanes 16..31; done exactly 17 cycles after each accept.
//  2 ADD func 000 with R0 lanes=32'hFFFF_FFFF, R1 lanes=1 -> R2 all 0 (wrap), R3 unchanged;
//    SUB func 001 with R0=5, R1=7 -> R2 lanes=32'hFFFF_FFFE.
//  3 MUL signed R0=-2, R1=3 -> R2=32'hFFFF_FFFA, R3=32'hFFFF_FFFF; unsigned same -> R3=32'h2.
//  4 STORE R2 addr 508 -> mem[508..511],mem[0..11] written; reLOAD R0 addr 508 matches R2.
//  5 ADD func 111 -> error=1, regs unchanged, done after 1 cycle; next valid instr clears error.
//  6 reset low at lane 7 of LOAD -> all R=0, busy=0, instr_ready=1 immediately; memory intact;
//    mem_we during busy op ignored (mem readback unchanged).

Source files
------------

// File: rtl/vec_proc_pkg.sv
// Shared definitions for the lane-serial vector processor: opcodes, function
// codes, controller states and instruction field positions.
package vec_proc_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_ADD   = 2'b10,
      OP_MUL   = 2'b11
   } op_e;

   localparam logic [2:0] FUNC_ADD   = 3'b000;
   localparam logic [2:0] FUNC_SUB   = 3'b001;
   localparam logic [2:0] FUNC_MUL_S = 3'b000;
   localparam logic [2:0] FUNC_MUL_U = 3'b001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STORE,
      ST_EXEC,
      ST_DONE
   } state_e;

   // Instruction layout: [15:14] op, [13:11] func, [10:9] reg, [ADDR_W-1:0] addr
   localparam int unsigned OP_LSB   = 14;
   localparam int unsigned FUNC_LSB = 11;
   localparam int unsigned REG_LSB  = 9;

   // LOAD/STORE ignore func; ADD and MUL each accept exactly two func codes.
   function automatic logic func_legal(input op_e op, input logic [2:0] func);
      case (op)
         OP_ADD:  return (func == FUNC_ADD) || (func == FUNC_SUB);
         OP_MUL:  return (func == FUNC_MUL_S) || (func == FUNC_MUL_U);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane arithmetic unit: modulo add/sub, or signed/unsigned multiply
// with the double-width product split into lo/hi halves.
module vec_lane_alu #(
   parameter int unsigned LANE_W = 32
) (
   input  logic [LANE_W-1:0] a_i,
   input  logic [LANE_W-1:0] b_i,
   input  logic              mul_i,
   input  logic              sub_i,
   input  logic              uns_i,
   output logic [LANE_W-1:0] lo_o,
   output logic [LANE_W-1:0] hi_o
);

   logic [2*LANE_W-1:0] a_x;
   logic [2*LANE_W-1:0] b_x;
   logic [2*LANE_W-1:0] prod;

   // Operands are widened (zero or sign) so one unsigned multiplier serves both modes.
   always_comb begin
      a_x  = uns_i ? {{LANE_W{1'b0}}, a_i} : {{LANE_W{a_i[LANE_W-1]}}, a_i};
      b_x  = uns_i ? {{LANE_W{1'b0}}, b_i} : {{LANE_W{b_i[LANE_W-1]}}, b_i};
      prod = a_x * b_x;
      if (mul_i) begin
         lo_o = prod[LANE_W-1:0];
         hi_o = prod[2*LANE_W-1:LANE_W];
      end else begin
         lo_o = sub_i ? (a_i - b_i) : (a_i + b_i);
         hi_o = '0;
      end
   end

endmodule

// File: rtl/vec_proc_param.sv
// Lane-serial vector processor: four LANES x LANE_W registers, a host-loadable
// word memory, and LOAD/STORE/ADD/MUL executed one lane per cycle.
module vec_proc_param
   import vec_proc_pkg::*;
#(
   parameter int unsigned LANES  = 16,
   parameter int unsigned LANE_W = 32,
   parameter int unsigned ADDR_W = 9
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [15:0]             instr,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic                    mem_we,
   input  logic [ADDR_W-1:0]       mem_waddr,
   input  logic [LANE_W-1:0]       mem_wdata,
   input  logic [1:0]              dbg_sel,
   output logic [LANES*LANE_W-1:0] dbg_data,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
   localparam int unsigned LANE_CW   = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(LANES - 1);

   state_e                    state_q, state_d;
   op_e                       op_q;
   logic [2:0]                func_q;
   logic [1:0]                reg_q;
   logic [ADDR_W-1:0]         addr_q;
   logic [LANE_CW-1:0]        lane_q;
   logic                      error_q;
   logic [LANES*LANE_W-1:0]   vreg_q [4];
   logic [LANE_W-1:0]         mem_q [MEM_DEPTH];

   op_e                       instr_op;
   logic [2:0]                instr_func;
   logic                      instr_legal;
   logic                      accept;
   logic                      in_op;
   logic [31:0]               lane_base;
   logic [ADDR_W-1:0]         lane_addr;
   logic [LANE_W-1:0]         mem_rdata;
   logic [LANE_W-1:0]         r0_lane, r1_lane, st_lane;
   logic [LANE_W-1:0]         alu_lo, alu_hi;

   assign instr_op    = op_e'(instr[OP_LSB +: 2]);
   assign instr_func  = instr[FUNC_LSB +: 3];
   assign instr_legal = func_legal(instr_op, instr_func);
   assign accept      = instr_valid && (state_q == ST_IDLE);
   assign in_op       = (state_q == ST_LOAD) || (state_q == ST_STORE) || (state_q == ST_EXEC);

   // Address arithmetic is ADDR_W wide, so addr+lane wraps modulo the memory depth.
   assign lane_base = 32'(lane_q) * LANE_W;
   assign lane_addr = addr_q + ADDR_W'(lane_q);
   assign mem_rdata = mem_q[lane_addr];
   assign r0_lane   = vreg_q[0][lane_base +: LANE_W];
   assign r1_lane   = vreg_q[1][lane_base +: LANE_W];
   assign st_lane   = vreg_q[reg_q][lane_base +: LANE_W];

   assign instr_ready = (state_q == ST_IDLE);
   assign busy        = in_op;
   assign done        = (state_q == ST_DONE);
   assign error       = error_q;
   assign dbg_data    = vreg_q[dbg_sel];

   vec_lane_alu #(
      .LANE_W (LANE_W)
   ) u_alu (
      .a_i   (r0_lane),
      .b_i   (r1_lane),
      .mul_i (op_q == OP_MUL),
      .sub_i (func_q == FUNC_SUB),
      .uns_i (func_q == FUNC_MUL_U),
      .lo_o  (alu_lo),
      .hi_o  (alu_hi)
   );

   // Controller state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: illegal func skips the lane phase; lane phases end on the last lane.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               if (!instr_legal) state_d = ST_DONE;
               else begin
                  case (instr_op)
                     OP_LOAD:  state_d = ST_LOAD;
                     OP_STORE: state_d = ST_STORE;
                     default:  state_d = ST_EXEC;
                  endcase
               end
            end
         end
         ST_LOAD, ST_STORE, ST_EXEC: if (lane_q == LAST_LANE) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Instruction latch, lane counter, sticky error and register-file lane writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q    <= OP_LOAD;
         func_q  <= '0;
         reg_q   <= '0;
         addr_q  <= '0;
         lane_q  <= '0;
         error_q <= 1'b0;
         for (int unsigned r = 0; r < 4; r++) vreg_q[r] <= '0;
      end else begin
         if (accept) begin
            op_q    <= instr_op;
            func_q  <= instr_func;
            reg_q   <= instr[REG_LSB +: 2];
            addr_q  <= instr[ADDR_W-1:0];
            lane_q  <= '0;
            error_q <= !instr_legal;
         end else if (in_op) begin
            lane_q <= (lane_q == LAST_LANE) ? '0 : lane_q + LANE_CW'(1);
         end
         if (state_q == ST_LOAD) vreg_q[reg_q][lane_base +: LANE_W] <= mem_rdata;
         if (state_q == ST_EXEC) begin
            vreg_q[2][lane_base +: LANE_W] <= alu_lo;
            if (op_q == OP_MUL) vreg_q[3][lane_base +: LANE_W] <= alu_hi;
         end
      end
   end

   // Word memory (not reset): STORE lanes while busy, host writes only when idle.
   always_ff @(posedge clk) begin
      if (state_q == ST_STORE)                 mem_q[lane_addr] <= st_lane;
      else if (mem_we && state_q == ST_IDLE)   mem_q[mem_waddr] <= mem_wdata;
   end

endmodule

// File: tb/tb_vec_proc_param.sv
// Randomized self-checking bench for vec_proc_param against a lane-array model.
module tb_vec_proc_param;

   localparam int LANES  = 16;
   localparam int LANE_W = 32;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 512;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [15:0]             instr = '0;
   logic                    instr_valid = 1'b0;
   logic                    instr_ready;
   logic                    mem_we = 1'b0;
   logic [ADDR_W-1:0]       mem_waddr = '0;
   logic [LANE_W-1:0]       mem_wdata = '0;
   logic [1:0]              dbg_sel = '0;
   logic [LANES*LANE_W-1:0] dbg_data;
   logic                    busy, done, error;

   logic [31:0] mem_m [DEPTH];
   logic [31:0] r_m [4][LANES];
   logic        err_m = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   always #10 clk = ~clk;

   vec_proc_param #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .mem_we      (mem_we),
      .mem_waddr   (mem_waddr),
      .mem_wdata   (mem_wdata),
      .dbg_sel     (dbg_sel),
      .dbg_data    (dbg_data),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] mk(input logic [1:0] op, input logic [2:0] func,
                                      input logic [1:0] r, input logic [8:0] a);
      return {op, func, r, a};
   endfunction

   function automatic logic [LANES*LANE_W-1:0] pack_reg(input int s);
      logic [LANES*LANE_W-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*32 +: 32] = r_m[s][i];
      return v;
   endfunction

   // Reference semantics of one instruction; returns expected accept-to-done latency.
   task automatic model_exec(input logic [15:0] ins, output int exp_lat);
      logic [1:0] op;
      logic [2:0] func;
      int         r, a;
      longint     p;
      longint unsigned pu;
      op = ins[15:14]; func = ins[13:11]; r = int'(ins[10:9]); a = int'(ins[8:0]);
      if (op >= 2 && func > 1) begin
         err_m = 1'b1; exp_lat = 1;
         return;
      end
      err_m = 1'b0; exp_lat = LANES + 1;
      for (int i = 0; i < LANES; i++) begin
         case (op)
            2'd0: r_m[r][i] = mem_m[(a + i) % DEPTH];
            2'd1: mem_m[(a + i) % DEPTH] = r_m[r][i];
            2'd2: r_m[2][i] = (func == 0) ? r_m[0][i] + r_m[1][i] : r_m[0][i] - r_m[1][i];
            default: begin
               if (func == 0) begin
                  p = longint'(signed'(r_m[0][i])) * longint'(signed'(r_m[1][i]));
                  r_m[2][i] = p[31:0]; r_m[3][i] = p[63:32];
               end else begin
                  pu = 64'(r_m[0][i]) * 64'(r_m[1][i]);
                  r_m[2][i] = pu[31:0]; r_m[3][i] = pu[63:32];
               end
            end
         endcase
      end
   endtask

   task automatic host_write(input logic [8:0] a, input logic [31:0] d);
      @(negedge clk); mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
      @(posedge clk); #1 mem_we = 1'b0;
      mem_m[a] = d;
   endtask

   // Offer one instruction in IDLE; lat = negedges after accept until done (-1 on timeout).
   task automatic issue(input logic [15:0] ins, output int lat);
      @(negedge clk); instr = ins; instr_valid = 1'b1;
      @(posedge clk); #1 instr_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin lat = c; break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic load_sources(input bit rnd, input logic [31:0] a, input logic [31:0] b);
      int lat, el;
      for (int i = 0; i < LANES; i++) host_write(9'(100 + i), rnd ? $urandom : a);
      for (int i = 0; i < LANES; i++) host_write(9'(116 + i), rnd ? $urandom : b);
      issue(mk(2'b00, 3'b000, 2'd0, 9'd100), lat); model_exec(mk(2'b00, 3'b000, 2'd0, 9'd100), el);
      issue(mk(2'b00, 3'b000, 2'd1, 9'd116), lat); model_exec(mk(2'b00, 3'b000, 2'd1, 9'd116), el);
   endtask

   task automatic test_reset;
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, error, instr_ready} !== 4'b0001) begin
         n_fail++; $display("FAIL reset_status got busy/done/err/rdy=%b exp=0001", {busy, done, error, instr_ready});
      end
      for (int s = 0; s < 4; s++) for (int i = 0; i < LANES; i++) r_m[s][i] = '0;
      for (int s = 0; s < 4; s++) begin
         dbg_sel = 2'(s); #1;
         n_tests++;
         if (dbg_data !== pack_reg(s)) begin
            n_fail++; $display("FAIL reset_regs R%0d got=%h exp=%h", s, dbg_data, pack_reg(s));
         end
      end
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_load;
      int lat, el;
      logic [15:0] ins;
      for (int k = 0; k < DEPTH; k++) host_write(9'(k), $urandom);
      for (int k = 0; k < 32; k++) host_write(9'(k), 32'(k));
      for (int n = 0; n < 5; n++) begin
         if (n == 0)      ins = mk(2'b00, 3'b000, 2'd0, 9'd0);
         else if (n == 1) ins = mk(2'b00, 3'b000, 2'd1, 9'd16);
         else ins = mk(2'b00, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
         issue(ins, lat); model_exec(ins, el);
         n_tests++;
         if (lat != el) begin n_fail++; $display("FAIL load_latency n=%0d got=%0d exp=%0d", n, lat, el); end
         if (n == 1) begin
            dbg_sel = 2'd1; #1;
            n_tests++;
            if (dbg_data[31:0] !== 32'd16 || dbg_data[511:480] !== 32'd31) begin
               n_fail++; $display("FAIL load_r1_ends got=%h/%h exp=00000010/0000001f", dbg_data[31:0], dbg_data[511:480]);
            end
         end
      end
      for (int s = 0; s < 4; s++) begin
         dbg_sel = 2'(s); #1;
         n_tests++;
         if (dbg_data !== pack_reg(s)) begin
            n_fail++; $display("FAIL load_regs R%0d got=%h exp=%h", s, dbg_data, pack_reg(s));
         end
      end
   endtask

   task automatic test_add_sub;
      int lat, el;
      logic [15:0] ins;
      for (int n = 0; n < 4; n++) begin
         case (n)
            0: load_sources(1'b0, 32'hFFFF_FFFF, 32'h1);
            1: load_sources(1'b0, 32'd5, 32'd7);
            default: load_sources(1'b1, '0, '0);
         endcase
         ins = mk(2'b10, (n == 1 || n == 3) ? 3'b001 : 3'b000, 2'($urandom), 9'($urandom));
         issue(ins, lat); model_exec(ins, el);
         n_tests++;
         if (lat != el) begin n_fail++; $display("FAIL addsub_latency n=%0d got=%0d exp=%0d", n, lat, el); end
         dbg_sel = 2'd2; #1;
         n_tests++;
         if (n == 0 && dbg_data !== '0) begin
            n_fail++; $display("FAIL add_wrap got=%h exp=0", dbg_data);
         end else if (n == 1 && dbg_data !== {LANES{32'hFFFF_FFFE}}) begin
            n_fail++; $display("FAIL sub_neg got=%h exp=fffffffe per lane", dbg_data);
         end
         for (int s = 0; s < 4; s++) begin
            dbg_sel = 2'(s); #1;
            n_tests++;
            if (dbg_data !== pack_reg(s)) begin
               n_fail++; $display("FAIL addsub_regs n=%0d R%0d got=%h exp=%h", n, s, dbg_data, pack_reg(s));
            end
         end
      end
   endtask

   task automatic test_mul;
      int lat, el;
      logic [15:0] ins;
      for (int n = 0; n < 4; n++) begin
         if (n < 2) load_sources(1'b0, 32'hFFFF_FFFE, 32'd3);
         else       load_sources(1'b1, '0, '0);
         ins = mk(2'b11, (n % 2 == 1) ? 3'b001 : 3'b000, 2'($urandom), 9'($urandom));
         issue(ins, lat); model_exec(ins, el);
         n_tests++;
         if (lat != el) begin n_fail++; $display("FAIL mul_latency n=%0d got=%0d exp=%0d", n, lat, el); end
         if (n < 2) begin
            dbg_sel = 2'd2; #1;
            n_tests++;
            if (dbg_data[31:0] !== 32'hFFFF_FFFA) begin
               n_fail++; $display("FAIL mul_lo n=%0d got=%h exp=fffffffa", n, dbg_data[31:0]);
            end
            dbg_sel = 2'd3; #1;
            n_tests++;
            if (dbg_data[31:0] !== ((n == 0) ? 32'hFFFF_FFFF : 32'h2)) begin
               n_fail++; $display("FAIL mul_hi n=%0d got=%h exp=%h", n, dbg_data[31:0], (n == 0) ? 32'hFFFF_FFFF : 32'h2);
            end
         end
         for (int s = 0; s < 4; s++) begin
            dbg_sel = 2'(s); #1;
            n_tests++;
            if (dbg_data !== pack_reg(s)) begin
               n_fail++; $display("FAIL mul_regs n=%0d R%0d got=%h exp=%h", n, s, dbg_data, pack_reg(s));
            end
         end
      end
   endtask

   task automatic test_wrap;
      int lat, el;
      logic [15:0] ins [4];
      logic [8:0]  ra;
      ra = 9'($urandom_range(490, 511));
      ins[0] = mk(2'b01, 3'b000, 2'd2, 9'd508);
      ins[1] = mk(2'b00, 3'b000, 2'd0, 9'd508);
      ins[2] = mk(2'b01, 3'($urandom), 2'd3, ra);
      ins[3] = mk(2'b00, 3'($urandom), 2'd1, ra);
      for (int n = 0; n < 4; n++) begin
         issue(ins[n], lat); model_exec(ins[n], el);
         n_tests++;
         if (lat != el) begin n_fail++; $display("FAIL wrap_latency n=%0d got=%0d exp=%0d", n, lat, el); end
      end
      for (int s = 0; s < 4; s++) begin
         dbg_sel = 2'(s); #1;
         n_tests++;
         if (dbg_data !== pack_reg(s)) begin
            n_fail++; $display("FAIL wrap_regs R%0d got=%h exp=%h", s, dbg_data, pack_reg(s));
         end
      end
   endtask

   task automatic test_illegal;
      int lat, el;
      logic [15:0] ins;
      for (int n = 0; n < 3; n++) begin
         if (n == 0)      ins = mk(2'b10, 3'b111, 2'($urandom), 9'($urandom));
         else if (n == 1) ins = mk(2'b11, 3'($urandom_range(2, 7)), 2'($urandom), 9'($urandom));
         else             ins = mk(2'b10, 3'b000, 2'($urandom), 9'($urandom));
         issue(ins, lat); model_exec(ins, el);
         n_tests++;
         if (lat != el) begin n_fail++; $display("FAIL illegal_latency n=%0d got=%0d exp=%0d", n, lat, el); end
         repeat (3) @(posedge clk);
         #1;
         n_tests++;
         if (error !== err_m) begin n_fail++; $display("FAIL illegal_error n=%0d got=%b exp=%b", n, error, err_m); end
         for (int s = 0; s < 4; s++) begin
            dbg_sel = 2'(s); #1;
            n_tests++;
            if (dbg_data !== pack_reg(s)) begin
               n_fail++; $display("FAIL illegal_regs n=%0d R%0d got=%h exp=%h", n, s, dbg_data, pack_reg(s));
            end
         end
      end
   endtask

   task automatic test_we_accept;
      int lat, el;
      logic [15:0] ins;
      logic [8:0]  a;
      logic [31:0] d;
      a = 9'($urandom_range(300, 400)); d = $urandom;
      ins = mk(2'b00, 3'b000, 2'd1, a);
      @(negedge clk);
      mem_we = 1'b1; mem_waddr = a; mem_wdata = d; instr = ins; instr_valid = 1'b1;
      @(posedge clk); #1 mem_we = 1'b0; instr_valid = 1'b0;
      mem_m[a] = d;
      model_exec(ins, el);
      lat = -1;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin lat = c; break; end
      end
      @(posedge clk); #1;
      n_tests++;
      if (lat != el) begin n_fail++; $display("FAIL we_accept_latency got=%0d exp=%0d", lat, el); end
      dbg_sel = 2'd1; #1;
      n_tests++;
      if (dbg_data !== pack_reg(1)) begin
         n_fail++; $display("FAIL we_accept_r1 got=%h exp=%h", dbg_data, pack_reg(1));
      end
   endtask

   task automatic test_back_to_back;
      int n, lat, el;
      logic rdy;
      logic [15:0] ia, ib;
      ia = mk(2'b00, 3'b000, 2'd3, 9'($urandom));
      ib = mk(2'b10, 3'b001, 2'd0, 9'd0);
      @(negedge clk); instr = ia; instr_valid = 1'b1;
      @(posedge clk); #1 instr = ib;
      n = 0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk); rdy = instr_ready;
         @(posedge clk); n++;
         if (rdy) break;
      end
      #1 instr_valid = 1'b0;
      n_tests++;
      if (n != LANES + 2) begin n_fail++; $display("FAIL b2b_interval got=%0d exp=%0d", n, LANES + 2); end
      lat = -1;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin lat = c; break; end
      end
      @(posedge clk); #1;
      model_exec(ia, el); model_exec(ib, el);
      n_tests++;
      if (lat != el) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, el); end
      for (int s = 0; s < 4; s++) begin
         dbg_sel = 2'(s); #1;
         n_tests++;
         if (dbg_data !== pack_reg(s)) begin
            n_fail++; $display("FAIL b2b_regs R%0d got=%h exp=%h", s, dbg_data, pack_reg(s));
         end
      end
   endtask

   task automatic test_reset_midop;
      int lat, el;
      logic [15:0] ins;
      logic [8:0]  a0;
      a0 = 9'($urandom_range(0, 511));
      ins = mk(2'b00, 3'b000, 2'd2, a0);
      @(negedge clk); instr = ins; instr_valid = 1'b1;
      @(posedge clk); #1 instr_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      for (int s = 0; s < 4; s++) for (int i = 0; i < LANES; i++) r_m[s][i] = '0;
      err_m = 1'b0;
      n_tests++;
      if ({busy, done, error, instr_ready} !== 4'b0001) begin
         n_fail++; $display("FAIL midop_reset_status got busy/done/err/rdy=%b exp=0001", {busy, done, error, instr_ready});
      end
      for (int s = 0; s < 4; s++) begin
         dbg_sel = 2'(s); #1;
         n_tests++;
         if (dbg_data !== pack_reg(s)) begin
            n_fail++; $display("FAIL midop_regs R%0d got=%h exp=%h", s, dbg_data, pack_reg(s));
         end
      end
      @(negedge clk) reset = 1'b1;
      // Host writes into the range being loaded while busy must be dropped.
      ins = mk(2'b00, 3'b000, 2'd0, a0);
      @(negedge clk); instr = ins; instr_valid = 1'b1;
      @(posedge clk); #1 instr_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({busy, instr_ready} !== 2'b10) begin
         n_fail++; $display("FAIL busy_status got busy/rdy=%b exp=10", {busy, instr_ready});
      end
      mem_we = 1'b1; mem_waddr = a0 + 9'd2; mem_wdata = ~mem_m[a0 + 9'd2];
      repeat (3) @(posedge clk);
      #1 mem_we = 1'b0;
      lat = -1;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin lat = c; break; end
      end
      @(posedge clk); #1;
      model_exec(ins, el);
      n_tests++;
      if (lat < 0) begin n_fail++; $display("FAIL busy_we_done got=%0d exp=%0d", lat, el); end
      ins = mk(2'b00, 3'b000, 2'd3, a0);
      issue(ins, lat); model_exec(ins, el);
      for (int s = 0; s < 4; s++) begin
         dbg_sel = 2'(s); #1;
         n_tests++;
         if (dbg_data !== pack_reg(s)) begin
            n_fail++; $display("FAIL mem_intact R%0d got=%h exp=%h", s, dbg_data, pack_reg(s));
         end
      end
   endtask

   initial begin
      test_reset;
      test_load;
      test_add_sub;
      test_mul;
      test_wrap;
      test_illegal;
      test_we_accept;
      test_back_to_back;
      test_reset_midop;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
